// File: rtl/gat_feature_reader_if.sv
// Feature readback stream bundle between gat_feature_reader (master) and the host DMA (slave).
// m_last_all exists only when GAT_FEATURE_READER_NODE_LAST_EN is defined.
interface gat_feature_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
    logic                  m_last_all;

    modport master (output m_data, m_valid, m_last, m_last_all, input m_ready);
    modport slave  (input m_data, m_valid, m_last, m_last_all, output m_ready);
`else
    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);
`endif
endinterface

// File: rtl/gat_feature_reader.sv
// Drains the new-feature BRAM in address order into a credit-controlled FIFO and a valid/ready stream.
// Optional macro GAT_FEATURE_READER_NODE_LAST_EN: m_last per node, m_last_all on the final word.
module gat_feature_reader #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int READ_LATENCY       = 2,
    parameter int FIFO_DEPTH         = READ_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [NEW_FEATURE_ADDR_W-1:0] feature_BRAM_addrb,
    input  logic [DATA_WIDTH-1:0]         feature_BRAM_dout,
    gat_feature_reader_if.master          m,
    output logic                          busy,
    output logic                          done
);
    localparam int CNT_W  = NEW_FEATURE_ADDR_W + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(READ_LATENCY + 2);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
        logic                  last_all;
`endif
    } entry_t;

    state_t                        state_q, state_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [NEW_FEATURE_ADDR_W-1:0] addrb_q, addrb_d;
    logic [CNT_W-1:0]              issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]              out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]              cap_cnt_q, cap_cnt_d;
    logic [READ_LATENCY:0]         vld_sr_q, vld_sr_d;
    logic [OUT_W-1:0]              outst_q, outst_d;
    entry_t [FIFO_DEPTH-1:0]       mem_q, mem_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]             fcount_q, fcount_d;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
    logic [CNT_W-1:0]              feat_cnt_q, feat_cnt_d;
`endif

    logic   pop, push, issue, credit_ok;
    entry_t new_entry;

    assign pop  = (fcount_q != '0) && m.m_ready;
    // Bit 0 lines up with the registered address; bit READ_LATENCY lines up with matching dout.
    assign push = vld_sr_q[READ_LATENCY];
    // Credit freed by a pop in this cycle is usable at once, so steady-state flow has no bubbles.
    assign credit_ok = (32'(outst_q) + 32'(fcount_q)) < (32'(FIFO_DEPTH) + 32'(pop));
    assign issue     = (state_q == S_READ) && credit_ok;

    always_comb begin
        new_entry      = '0;
        new_entry.data = feature_BRAM_dout;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
        new_entry.last     = (feat_cnt_q == CNT_W'(NUM_FEATURE_OUT - 1));
        new_entry.last_all = (cap_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1));
`else
        new_entry.last     = (cap_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1));
`endif
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        addrb_d     = addrb_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = pop  ? out_cnt_q + CNT_W'(1) : out_cnt_q;
        cap_cnt_d   = push ? cap_cnt_q + CNT_W'(1) : cap_cnt_q;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
        feat_cnt_d  = feat_cnt_q;
        if (push)
            feat_cnt_d = (feat_cnt_q == CNT_W'(NUM_FEATURE_OUT - 1)) ? '0 : feat_cnt_q + CNT_W'(1);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READ;
                    busy_d      = 1'b1;
                    addrb_d     = '0;
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    cap_cnt_d   = '0;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
                    feat_cnt_d  = '0;
`endif
                end
            end
            S_READ: begin
                if (issue) begin
                    addrb_d     = issue_cnt_q[NEW_FEATURE_ADDR_W-1:0];
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (out_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_sr_d = {vld_sr_q[READ_LATENCY-1:0], issue};
        outst_d  = outst_q + OUT_W'(issue) - OUT_W'(push);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcount_d = fcount_q + FCNT_W'(push) - FCNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addrb_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            vld_sr_q    <= '0;
            outst_q     <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcount_q    <= '0;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
            feat_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addrb_q     <= addrb_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            vld_sr_q    <= vld_sr_d;
            outst_q     <= outst_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcount_q    <= fcount_d;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
            feat_cnt_q  <= feat_cnt_d;
`endif
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fcount_q == FCNT_W'(FIFO_DEPTH))));

    assign feature_BRAM_addrb = addrb_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign m.m_valid          = (fcount_q != '0);
    assign m.m_data           = mem_q[rd_ptr_q].data;
    assign m.m_last           = mem_q[rd_ptr_q].last;
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
    assign m.m_last_all       = mem_q[rd_ptr_q].last_all;
`endif
endmodule

// File: tb/tb_gat_feature_reader.sv
// Scoreboard bench for gat_feature_reader: BRAM model returns addr+3, monitor checks the stream.
module tb_gat_feature_reader;
    localparam int DW    = 8;
    localparam int NS    = 2;
    localparam int NFO   = 4;
    localparam int DEPTH = NS * NFO;
    localparam int AW    = $clog2(DEPTH);
    localparam int RL    = 2;
    localparam int FD    = RL + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;

    gat_feature_reader_if #(.DATA_WIDTH(DW)) sif ();

    gat_feature_reader #(
        .DATA_WIDTH(DW),
        .NUM_SUBGRAPHS(NS),
        .NUM_FEATURE_OUT(NFO),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .feature_BRAM_addrb(addrb),
        .feature_BRAM_dout(dout),
        .m(sif),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // BRAM with RL cycles from address change to data.
    logic [AW-1:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= addrb;
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign dout = DW'(pipe[RL-1]) + DW'(3);

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          la;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int start_at = 0;
    int done_cnt = 0;
    int popped_run = 0;
    bit lat_check = 0;
    bit done_due = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addrb = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: word i carries i+3; last flags from index arithmetic alone.
    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            e.d  = DW'(i + 3);
            e.la = (i == DEPTH - 1);
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
            e.l  = ((i % NFO) == NFO - 1);
`else
            e.l  = (i == DEPTH - 1);
`endif
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
            done_due   = 0;
        end else begin
            if (done_due || done) begin
                chk("done_timing", 32'(done), 32'(done_due));
                if (done) done_cnt++;
            end
            done_due = 0;
            if (prev_stall) begin
                chk("hold_valid", 32'(sif.m_valid), 32'd1);
                chk("hold_data", 32'(sif.m_data), 32'(prev_data));
            end
            if (lat_check && sif.m_valid) begin
                chk("first_valid_latency", 32'(cyc_cnt - start_at), 32'(RL + 2));
                lat_check = 0;
            end
            if (sif.m_valid && sif.m_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected no word", sif.m_data);
                end else begin
                    e = sb.pop_front();
                    chk("data", 32'(sif.m_data), 32'(e.d));
                    chk("last", 32'(sif.m_last), 32'(e.l));
`ifdef GAT_FEATURE_READER_NODE_LAST_EN
                    chk("last_all", 32'(sif.m_last_all), 32'(e.la));
`endif
                    if (e.la) done_due = 1;
                end
                popped_run++;
            end
            if (addrb != prev_addrb)
                chk("credit_bound", 32'((int'(addrb) + 1 - popped_run) <= FD), 32'd1);
            prev_addrb = addrb;
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_addrb", 32'(addrb), 32'd0);
        chk("rst_valid", 32'(sif.m_valid), 32'd0);
        chk("rst_data", 32'(sif.m_data), 32'd0);
        chk("rst_last", 32'(sif.m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: ready high, 1: ready low until cycle 12, 2: random ready,
    // 3: extra start at cycle 5, 4: reset after three handshakes
    task automatic run(input int mode, input bit with_lat);
        int d0;
        d0 = done_cnt;
        push_expected();
        popped_run = 0;
        lat_check  = with_lat;
        start = 1'b1;
        sif.m_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start_at = cyc_cnt;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int c = 1; c <= 300 && done_cnt == d0; c++) begin
            case (mode)
                1: begin
                    if (c == 12) begin
                        chk("bp_issue_limit", 32'(addrb <= AW'(FD - 1)), 32'd1);
                        chk("bp_hold_valid", 32'(sif.m_valid), 32'd1);
                        chk("bp_hold_data", 32'(sif.m_data), 32'd3);
                    end
                    sif.m_ready = (c >= 12);
                end
                2: sif.m_ready = 1'($urandom_range(0, 1));
                3: begin
                    sif.m_ready = 1'b1;
                    start = (c == 5);
                end
                4: begin
                    sif.m_ready = 1'b1;
                    if (popped_run == 3) begin
                        rst = 1'b1;
                        @(posedge clk);
                        #1;
                        check_reset_outputs();
                        rst = 1'b0;
                        sb.delete();
                        idle_cycles(6);
                        chk("rst_no_done", 32'(done_cnt), 32'(d0));
                        chk("rst_idle_busy", 32'(busy), 32'd0);
                        return;
                    end
                end
                default: sif.m_ready = 1'b1;
            endcase
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
        chk("busy_cleared", 32'(busy), 32'd0);
        sif.m_ready = 1'b1;
        idle_cycles(5);
        chk("words_delivered", 32'(sb.size()), 32'd0);
        chk("single_done", 32'(done_cnt), 32'(d0 + 1));
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sif.m_ready = 1'b0;
        idle_cycles(3);
        check_reset_outputs();
        rst = 1'b0;
        idle_cycles(2);
        run(0, 1'b1);
        run(1, 1'b0);
        run(4, 1'b0);
        run(0, 1'b1);
        run(3, 1'b0);
        for (int r = 0; r < 1000; r++) run(2, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "watchdog");
    end
endmodule
